// File: rtl/idma_2d_midend_lite.sv
// Lightweight 2D midend: expands one 2D job into a stream of strided 1D bursts
// for the iDMA backend and folds the backend responses into one job response.

package idma_2d_midend_lite_pkg;
   // Default 1D request layout; any struct with src_addr/dst_addr fields can be used.
   typedef struct packed {
      logic [31:0] length;
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [7:0]  opt;
   } idma_req_t;

   // Default backend response layout; only the error bit is interpreted.
   typedef struct packed {
      logic [7:0] info;
      logic       error;
   } idma_rsp_t;
endpackage

module idma_2d_midend_lite #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned RepWidth       = 32,
   parameter int unsigned MaxOutstanding = 8,
   parameter type idma_req_t = idma_2d_midend_lite_pkg::idma_req_t,
   parameter type idma_rsp_t = idma_2d_midend_lite_pkg::idma_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  idma_req_t            nd_req_i,
   input  logic [RepWidth-1:0]  reps_i,
   input  logic [AddrWidth-1:0] src_stride_i,
   input  logic [AddrWidth-1:0] dst_stride_i,
   input  logic                 nd_req_valid_i,
   output logic                 nd_req_ready_o,
   output idma_rsp_t            nd_rsp_o,
   output logic                 nd_rsp_valid_o,
   input  logic                 nd_rsp_ready_i,
   output idma_req_t            burst_req_o,
   output logic                 burst_req_valid_o,
   input  logic                 burst_req_ready_i,
   input  idma_rsp_t            burst_rsp_i,
   input  logic                 burst_rsp_valid_i,
   output logic                 burst_rsp_ready_o,
   output logic                 busy_o
);

   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
   localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      RESP
   } state_e;

   state_e               state_q, state_d;
   logic                 ready_q;
   idma_req_t            req_q;
   idma_rsp_t            rsp_q;
   logic [RepWidth-1:0]  reps_q;
   logic [RepWidth-1:0]  issued_q;
   logic [OutW-1:0]      outstanding_q;
   logic [AddrWidth-1:0] src_stride_q;
   logic [AddrWidth-1:0] dst_stride_q;
   logic                 error_sticky_q;
   logic                 job_hs;
   logic                 burst_hs;
   logic                 rsp_hs;

   // The current burst is the latched request whose addresses advance in place.
   assign burst_req_o = req_q;
   assign busy_o      = (state_q != IDLE);

   // Job ready is registered so it stays low while reset is asserted.
   assign nd_req_ready_o = ready_q;

   // Merged response: last captured backend response with the accumulated error.
   always_comb begin
      nd_rsp_o       = rsp_q;
      nd_rsp_o.error = error_sticky_q;
   end

   // State register plus the registered job-ready flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE);
      end
   end

   // Handshake-qualified outputs and next-state selection.
   always_comb begin
      state_d           = state_q;
      burst_req_valid_o = 1'b0;
      burst_rsp_ready_o = 1'b0;
      nd_rsp_valid_o    = 1'b0;
      job_hs            = 1'b0;
      burst_hs          = 1'b0;
      rsp_hs            = 1'b0;
      case (state_q)
         IDLE: begin
            job_hs = nd_req_valid_i && ready_q;
            if (job_hs) begin
               state_d = (reps_i == '0) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            burst_req_valid_o = (outstanding_q < MaxOut);
            burst_rsp_ready_o = 1'b1;
            burst_hs          = burst_req_valid_o && burst_req_ready_i;
            rsp_hs            = burst_rsp_valid_i;
            if (burst_hs && ((issued_q + RepWidth'(1)) == reps_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            burst_rsp_ready_o = 1'b1;
            rsp_hs            = burst_rsp_valid_i;
            if ((outstanding_q == '0) || (rsp_hs && (outstanding_q == OutW'(1)))) begin
               state_d = RESP;
            end
         end
         RESP: begin
            nd_rsp_valid_o = 1'b1;
            if (nd_rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Job latching, address stepping, burst accounting and response merging.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q          <= '0;
         rsp_q          <= '0;
         reps_q         <= '0;
         issued_q       <= '0;
         outstanding_q  <= '0;
         src_stride_q   <= '0;
         dst_stride_q   <= '0;
         error_sticky_q <= 1'b0;
      end else if (job_hs) begin
         req_q          <= nd_req_i;
         rsp_q          <= '0;
         reps_q         <= reps_i;
         issued_q       <= '0;
         outstanding_q  <= '0;
         src_stride_q   <= src_stride_i;
         dst_stride_q   <= dst_stride_i;
         error_sticky_q <= 1'b0;
      end else begin
         if (burst_hs) begin
            issued_q       <= issued_q + RepWidth'(1);
            req_q.src_addr <= req_q.src_addr + src_stride_q;
            req_q.dst_addr <= req_q.dst_addr + dst_stride_q;
         end
         case ({burst_hs, rsp_hs})
            2'b10:   outstanding_q <= outstanding_q + OutW'(1);
            2'b01:   outstanding_q <= outstanding_q - OutW'(1);
            default: outstanding_q <= outstanding_q;
         endcase
         if (rsp_hs) begin
            rsp_q          <= burst_rsp_i;
            error_sticky_q <= error_sticky_q | burst_rsp_i.error;
         end
      end
   end

endmodule

// File: tb/tb_idma_2d_midend_lite.sv
// Self-checking bench for idma_2d_midend_lite: a count-based model of the job
// (bursts issued, bursts outstanding, responses merged) predicts every cycle.

module tb_idma_2d_midend_lite;

   typedef idma_2d_midend_lite_pkg::idma_req_t req_t;
   typedef idma_2d_midend_lite_pkg::idma_rsp_t rsp_t;

   localparam int MaxOut = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   req_t        nd_req;
   logic [31:0] reps;
   logic [31:0] sstr;
   logic [31:0] dstr;
   logic        nd_req_valid;
   logic        nd_req_ready;
   rsp_t        nd_rsp;
   logic        nd_rsp_valid;
   logic        nd_rsp_ready;
   req_t        burst_req;
   logic        burst_req_valid;
   logic        burst_req_ready;
   rsp_t        burst_rsp;
   logic        burst_rsp_valid;
   logic        burst_rsp_ready;
   logic        busy;

   int total = 0;
   int bad   = 0;

   // Observations from the most recent job, for scenario-specific checks.
   logic [31:0] src_seen[32];
   logic [31:0] dst_seen[32];
   rsp_t        rsp_seen;
   logic [7:0]  last_info_g;
   int          vhold;
   int          first_ndv_cyc;

   idma_2d_midend_lite #(
      .AddrWidth     (32),
      .RepWidth      (32),
      .MaxOutstanding(MaxOut)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .nd_req_i         (nd_req),
      .reps_i           (reps),
      .src_stride_i     (sstr),
      .dst_stride_i     (dstr),
      .nd_req_valid_i   (nd_req_valid),
      .nd_req_ready_o   (nd_req_ready),
      .nd_rsp_o         (nd_rsp),
      .nd_rsp_valid_o   (nd_rsp_valid),
      .nd_rsp_ready_i   (nd_rsp_ready),
      .burst_req_o      (burst_req),
      .burst_req_valid_o(burst_req_valid),
      .burst_req_ready_i(burst_req_ready),
      .burst_rsp_i      (burst_rsp),
      .burst_rsp_valid_i(burst_rsp_valid),
      .burst_rsp_ready_o(burst_rsp_ready),
      .busy_o           (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic idle_inputs();
      nd_req          = '0;
      reps            = '0;
      sstr            = '0;
      dstr            = '0;
      nd_req_valid    = 1'b0;
      nd_rsp_ready    = 1'b0;
      burst_req_ready = 1'b0;
      burst_rsp       = '0;
      burst_rsp_valid = 1'b0;
   endtask

   // Runs one job against the model; called at posedge+1, returns at posedge+1.
   task automatic drive_job(input req_t base, input logic [31:0] nreps,
                            input logic [31:0] s_str, input logic [31:0] d_str,
                            input int delay, input bit rnd, input int hold,
                            input logic [31:0] errmask, input int rst_at);
      int         issued, outs, resp_cnt, cyc;
      bit         done, aborted, err_acc, exp_valid, exp_rrdy, exp_ndv, bh, rh;
      logic [7:0] last_info;
      logic [7:0] infos[$];
      int         due[$];
      req_t       exp_b;
      rsp_t       exp_r;
      issued = 0; outs = 0; resp_cnt = 0; cyc = 0;
      done = 0; aborted = 0; err_acc = 0; last_info = '0;
      vhold = 0; first_ndv_cyc = -1; rsp_seen = '0;
      nd_req       = base;
      reps         = nreps;
      sstr         = s_str;
      dstr         = d_str;
      nd_req_valid = 1'b1;
      @(negedge clk);
      total++;
      if (nd_req_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL job_ready got=%b exp=1", nd_req_ready);
      end
      @(posedge clk); #1;
      nd_req_valid = 1'b0;
      nd_req       = req_t'({$urandom, $urandom, $urandom, $urandom});
      while (!done && !aborted && cyc < 3000) begin
         burst_req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         nd_rsp_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (due.size() > 0 && cyc >= due[0] && cyc >= hold) begin
            burst_rsp_valid = 1'b1;
            burst_rsp.info  = infos[0];
            burst_rsp.error = errmask[resp_cnt[4:0]];
         end else begin
            burst_rsp_valid = 1'b0;
            burst_rsp       = '0;
         end
         if (cyc == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            total++;
            if ({burst_req_valid, nd_rsp_valid, burst_rsp_ready, busy, nd_req_ready} !== 5'b0) begin
               bad++;
               $display("[TB] FAIL async_reset got=%b exp=00000",
                        {burst_req_valid, nd_rsp_valid, burst_rsp_ready, busy, nd_req_ready});
            end
            idle_inputs();
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            aborted = 1;
         end else begin
            @(negedge clk);
            exp_valid = (issued < nreps) && (outs < MaxOut);
            exp_rrdy  = (issued < nreps) || (outs > 0);
            exp_ndv   = (issued == nreps) && (outs == 0);
            exp_b          = base;
            exp_b.src_addr = base.src_addr + 32'(issued) * s_str;
            exp_b.dst_addr = base.dst_addr + 32'(issued) * d_str;
            exp_r          = '0;
            if (resp_cnt > 0) exp_r.info = last_info;
            exp_r.error = err_acc;
            if (cyc < hold && burst_req_valid === 1'b1) vhold++;
            if (nd_rsp_valid === 1'b1 && first_ndv_cyc < 0) first_ndv_cyc = cyc;
            total++;
            if (burst_req_valid !== exp_valid) begin
               bad++;
               $display("[TB] FAIL burst_valid cyc=%0d got=%b exp=%b", cyc, burst_req_valid, exp_valid);
            end
            if (exp_valid) begin
               total++;
               if (burst_req !== exp_b) begin
                  bad++;
                  $display("[TB] FAIL burst_payload k=%0d got=%h exp=%h", issued, burst_req, exp_b);
               end
            end
            total++;
            if (burst_rsp_ready !== exp_rrdy) begin
               bad++;
               $display("[TB] FAIL rsp_ready cyc=%0d got=%b exp=%b", cyc, burst_rsp_ready, exp_rrdy);
            end
            total++;
            if (nd_rsp_valid !== exp_ndv) begin
               bad++;
               $display("[TB] FAIL nd_rsp_valid cyc=%0d got=%b exp=%b", cyc, nd_rsp_valid, exp_ndv);
            end
            if (exp_ndv) begin
               total++;
               if (nd_rsp !== exp_r) begin
                  bad++;
                  $display("[TB] FAIL nd_rsp got=%h exp=%h", nd_rsp, exp_r);
               end
            end
            total++;
            if (busy !== 1'b1 || nd_req_ready !== 1'b0) begin
               bad++;
               $display("[TB] FAIL busy_ready got=%b%b exp=10", busy, nd_req_ready);
            end
            bh = exp_valid && burst_req_ready;
            rh = burst_rsp_valid && exp_rrdy;
            if (rh) begin
               outs--;
               last_info = infos.pop_front();
               void'(due.pop_front());
               err_acc = err_acc | errmask[resp_cnt[4:0]];
               resp_cnt++;
            end
            if (bh) begin
               if (issued < 32) begin
                  src_seen[issued] = burst_req.src_addr;
                  dst_seen[issued] = burst_req.dst_addr;
               end
               issued++;
               outs++;
               due.push_back(cyc + delay);
               infos.push_back(8'($urandom));
            end
            if (exp_ndv && nd_rsp_ready) begin
               done     = 1;
               rsp_seen = nd_rsp;
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      last_info_g = last_info;
      if (!aborted) begin
         total++;
         if (!done) begin
            bad++;
            $display("[TB] FAIL job_timeout got=%0d cycles exp=completion", cyc);
         end
         total++;
         if (busy !== 1'b0 || nd_req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL back_to_idle got=%b%b exp=01", busy, nd_req_ready);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({burst_req_valid, nd_rsp_valid, burst_rsp_ready, busy, nd_req_ready} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs got=%b exp=00000",
                  {burst_req_valid, nd_rsp_valid, burst_rsp_ready, busy, nd_req_ready});
      end
      total++;
      if (burst_req !== '0 || nd_rsp !== '0) begin
         bad++;
         $display("[TB] FAIL reset_payload got=%h/%h exp=0", burst_req, nd_rsp);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (nd_req_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_after_reset got=%b%b exp=10", nd_req_ready, busy);
      end
   endtask

   task automatic test_basic();
      req_t b;
      b = '{length: 32'h40, src_addr: 32'h1000, dst_addr: 32'h8000, opt: 8'h5A};
      drive_job(b, 4, 32'h100, 32'h40, 2, 0, 0, 32'h0, -1);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (src_seen[k] !== 32'h1000 + 32'(k) * 32'h100 || dst_seen[k] !== 32'h8000 + 32'(k) * 32'h40) begin
            bad++;
            $display("[TB] FAIL basic_addr k=%0d got=%h/%h", k, src_seen[k], dst_seen[k]);
         end
      end
      total++;
      if (rsp_seen.error !== 1'b0) begin
         bad++;
         $display("[TB] FAIL basic_error got=%b exp=0", rsp_seen.error);
      end
   endtask

   task automatic test_limit();
      req_t b;
      b = '{length: 32'h10, src_addr: 32'h2000, dst_addr: 32'h3000, opt: 8'h11};
      drive_job(b, 6, 32'h20, 32'h20, 1, 0, 10, 32'h0, -1);
      total++;
      if (vhold !== 2) begin
         bad++;
         $display("[TB] FAIL limit_valid_cycles got=%0d exp=2", vhold);
      end
      drive_job(b, 6, 32'h20, 32'h8, 3, 1, 0, 32'h0, -1);
   endtask

   task automatic test_error();
      req_t b;
      b = '{length: 32'h8, src_addr: 32'h400, dst_addr: 32'h900, opt: 8'h22};
      drive_job(b, 3, 32'h8, 32'h8, 2, 0, 0, 32'b010, -1);
      total++;
      if (rsp_seen.error !== 1'b1 || rsp_seen.info !== last_info_g) begin
         bad++;
         $display("[TB] FAIL error_merge got=%h exp=%h", rsp_seen, {last_info_g, 1'b1});
      end
   endtask

   task automatic test_zero_wrap();
      req_t b;
      b = '{length: 32'h4, src_addr: 32'hFFFFFF00, dst_addr: 32'h10, opt: 8'h33};
      drive_job(b, 0, 32'h100, 32'h4, 1, 0, 0, 32'h0, -1);
      total++;
      if (rsp_seen !== '0 || first_ndv_cyc !== 0) begin
         bad++;
         $display("[TB] FAIL zero_reps got=%h@%0d exp=0@0", rsp_seen, first_ndv_cyc);
      end
      drive_job(b, 2, 32'h100, 32'h4, 1, 0, 0, 32'h0, -1);
      total++;
      if (src_seen[1] !== 32'h0) begin
         bad++;
         $display("[TB] FAIL wrap_src got=%h exp=00000000", src_seen[1]);
      end
   endtask

   task automatic test_reset_mid();
      req_t b;
      b = '{length: 32'h20, src_addr: 32'h5000, dst_addr: 32'h6000, opt: 8'h44};
      drive_job(b, 6, 32'h10, 32'h10, 1, 0, 1000, 32'h0, 4);
      drive_job(b, 1, 32'h10, 32'h10, 1, 0, 0, 32'h0, -1);
      total++;
      if (src_seen[0] !== 32'h5000) begin
         bad++;
         $display("[TB] FAIL post_reset_src got=%h exp=00005000", src_seen[0]);
      end
   endtask

   task automatic test_back_to_back();
      req_t b;
      for (int j = 0; j < 8; j++) begin
         b = req_t'({$urandom, $urandom, $urandom, $urandom});
         drive_job(b, 32'($urandom_range(0, 10)), $urandom, $urandom,
                   int'($urandom_range(0, 4)), 1, 0, $urandom, -1);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_basic();
      test_limit();
      test_error();
      test_zero_wrap();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
